// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch stage.
//   fetch_state_t - fetch controller states
//   fetch_entry_t - one buffered instruction: its PC, the word, and a misalignment fault flag
//   FETCH_NOP     - word stored for faulted (misaligned) fetches
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;
  localparam logic [31:0] FETCH_NOP = 32'h00000000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch_entry_t.
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   clear_i        - synchronous clear, wins over push/pop
//   push_i, data_i - write an entry at the tail
//   pop_i          - drop the head entry
//   head_o         - head entry (meaningful only while count_o != 0)
//   count_o        - current occupancy, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_q, wr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;
  assign do_pop  = pop_i & (count_q != '0);
  // A push into a full buffer is only safe when the head leaves on the same edge.
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction memory fetch with a tagged output FIFO.
//   clock, reset_n                 - rising-edge clock, asynchronous active-low reset
//   pc_in, pc_valid, pc_ready      - fetch address handshake from the program counter
//   flush                          - discard buffered and in-flight instructions
//   mem_req, mem_addr, mem_gnt     - instruction memory request channel
//   mem_rvalid, mem_rdata          - instruction memory response channel
//   instr_valid, instr_ready       - decode handshake on the FIFO head
//   instr_out, instr_pc, instr_fault - head entry, forced to 0 while instr_valid is low
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t  state_q, state_d;
  logic [31:0]   mem_addr_q;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;
  logic          accept, aligned, push;
  assign aligned = pc_in[1:0] == 2'b00;
  // Leaving IDLE only with a free slot reserves room for the eventual response.
  assign pc_ready = reset_n & (state_q == IDLE) & !flush & (count < CW'(DEPTH));
  assign accept   = pc_valid & pc_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (accept & aligned) ? REQ : IDLE;
      REQ:     state_d = mem_gnt ? (flush ? DROP : WAIT) : (flush ? IDLE : REQ);
      WAIT:    state_d = mem_rvalid ? IDLE : (flush ? DROP : WAIT);
      default: state_d = mem_rvalid ? IDLE : DROP;
    endcase
  end
  // Misaligned PCs bypass memory and enter the FIFO as faulted NOPs; a flush kills a response in WAIT.
  assign push      = (accept & !aligned) | ((state_q == WAIT) & mem_rvalid & !flush);
  assign push_data = (state_q == WAIT) ? fetch_entry_t'{pc: mem_addr_q, instr: mem_rdata, fault: 1'b0}
                                       : fetch_entry_t'{pc: pc_in, instr: FETCH_NOP, fault: 1'b1};
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept & aligned) mem_addr_q <= pc_in;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (instr_valid & instr_ready),
    .head_o  (head),
    .count_o (count)
  );
  assign mem_req     = state_q == REQ;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = count != '0;
  assign instr_out   = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign instr_fault = instr_valid & head.fault;
endmodule
